// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDW          = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk_50m,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_en_n,
  input  logic                   tx_busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   frame_done,
  output logic                   timeout_err
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d, grant_id_q, grant_id_d, win;
  logic [7:0] tx_data_q, tx_data_d, win_byte;
  logic tx_en_n_q, tx_en_n_d, frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic grant, expire;
  // Rotating search: the smallest offset from last+1 with a valid request wins
  always_comb begin
    win = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[idx]) win = idx;
    end
  end
  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == IDW'(i)) win_byte = req_data[8*i +: 8];
  end
  assign grant     = (state_q == IDLE) && !tx_busy && |req_valid && !rst;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign expire    = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == CW'(BUSY_TIMEOUT - 1));
  always_ff @(posedge clk_50m) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = grant ? LAUNCH : IDLE;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : (expire ? IDLE : WAIT_BUSY);
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_data_d     = grant ? win_byte : tx_data_q;
    grant_id_d    = grant ? win : grant_id_q;
    last_d        = grant ? win : last_q;
    tx_en_n_d     = !grant;
    cnt_d         = (state_q == LAUNCH) ? '0 :
                    ((state_q == WAIT_BUSY) && !tx_busy) ? cnt_q + 1'b1 : cnt_q;
    frame_done_d  = (state_q == WAIT_DONE) && !tx_busy;
    timeout_err_d = timeout_err_q | expire;
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      last_q        <= IDW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_en_n_q     <= 1'b1;
      cnt_q         <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      last_q        <= last_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_en_n_q     <= tx_en_n_d;
      cnt_q         <= cnt_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign tx_data     = tx_data_q;
  assign tx_en_n     = tx_en_n_q;
  assign grant_id    = grant_id_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus hand sequences; strobed bytes are checked against a scoreboard queue
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk_50m = 1'b0;
  logic rst = 1'b1;
  logic tx_busy = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic [7:0] tx_data;
  logic tx_en_n, frame_done, timeout_err;
  logic [1:0] grant_id;
  int total = 0;
  int bad = 0;
  logic [9:0] sb[$];
  typedef struct {
    bit          do_rst;
    bit          rise;
    logic [3:0]  mask;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_data;
  } vec_t;
  vec_t v[13];

  uart_tx_arbiter #(.NUM_REQ(N), .IDW(2), .BUSY_TIMEOUT(16)) dut (
    .clk_50m(clk_50m), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_en_n(tx_en_n), .tx_busy(tx_busy),
    .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe must match the oldest expected {grant_id, byte}
  always @(negedge clk_50m) begin
    logic [9:0] e;
    if (rst === 1'b0 && tx_en_n === 1'b0) begin
      if (sb.size() == 0) chk("unexpected_strobe", 32'(tx_en_n), 32'd1);
      else begin
        e = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("grant_id", 32'(grant_id), 32'(e[9:8]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    tx_busy = 1'b0;
    @(negedge clk_50m); #1;
    chk("rst_tx_en_n", 32'(tx_en_n), 32'd1);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic grant(input logic [3:0] mask, input logic [31:0] data, input int id, input logic [7:0] d);
    int n;
    n = 0;
    req_valid = mask;
    req_data = data;
    #1;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk_50m); #1;
      n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1 << id);
    sb.push_back({2'(id), d});
    @(negedge clk_50m); #1;
    chk("tx_en_n_low", 32'(tx_en_n), 32'd0);
    chk("ready_launch", 32'(req_ready), 32'd0);
  endtask

  task automatic finish_frame(input bit rise);
    int k;
    bit saw;
    k = 0;
    saw = 1'b0;
    if (rise) begin
      tx_busy = 1'b1;
      repeat (3) begin
        @(negedge clk_50m); #1;
        chk("ready_busy", 32'(req_ready), 32'd0);
        chk("no_done_early", 32'(frame_done), 32'd0);
      end
      tx_busy = 1'b0;
      @(negedge clk_50m); #1;
      chk("frame_done", 32'(frame_done), 32'd1);
    end else begin
      while (timeout_err !== 1'b1 && k < 40) begin
        @(negedge clk_50m); #1;
        k++;
        if (frame_done === 1'b1) saw = 1'b1;
      end
      chk("timeout_cycles", 32'(k), 32'd17);
      chk("timeout_no_done", 32'(saw), 32'd0);
    end
  endtask

  initial begin
    v[0]  = '{1'b1, 1'b1, 4'b0100, 32'h00A50000, 2, 8'hA5};
    v[1]  = '{1'b1, 1'b1, 4'b1111, 32'h44332211, 0, 8'h11};
    v[2]  = '{1'b0, 1'b1, 4'b1111, 32'h48372615, 1, 8'h26};
    v[3]  = '{1'b0, 1'b1, 4'b1111, 32'h5C4B3A29, 2, 8'h4B};
    v[4]  = '{1'b0, 1'b1, 4'b1111, 32'h6F5E4D3C, 3, 8'h6F};
    v[5]  = '{1'b0, 1'b1, 4'b1111, 32'h01020304, 0, 8'h04};
    v[6]  = '{1'b0, 1'b1, 4'b1000, 32'h77000000, 3, 8'h77};
    v[7]  = '{1'b0, 1'b1, 4'b1010, 32'h88009900, 1, 8'h99};
    v[8]  = '{1'b0, 1'b1, 4'b1010, 32'h8800AA00, 3, 8'h88};
    v[9]  = '{1'b0, 1'b1, 4'b1000, 32'hBB000000, 3, 8'hBB};
    v[10] = '{1'b0, 1'b1, 4'b1001, 32'hC00000DD, 0, 8'hDD};
    v[11] = '{1'b0, 1'b0, 4'b0100, 32'h00EE0000, 2, 8'hEE};
    v[12] = '{1'b0, 1'b1, 4'b0110, 32'h0012F300, 1, 8'hF3};
    for (int i = 0; i < 13; i++) begin
      if (v[i].do_rst) do_reset();
      grant(v[i].mask, v[i].data, v[i].exp_id, v[i].exp_data);
      finish_frame(v[i].rise);
    end
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    // Reset while the transmitter is still busy: no strobe until tx_busy falls
    grant(4'b0001, 32'h0000005A, 0, 8'h5A);
    tx_busy = 1'b1;
    @(negedge clk_50m); #1;
    @(negedge clk_50m); #1;
    rst = 1'b1;
    @(negedge clk_50m); #1;
    chk("mid_rst_tx_en_n", 32'(tx_en_n), 32'd1);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk_50m); #1;
      chk("busy_after_rst_ready", 32'(req_ready), 32'd0);
      chk("busy_after_rst_tx_en_n", 32'(tx_en_n), 32'd1);
    end
    tx_busy = 1'b0;
    grant(4'b0001, 32'h000000C7, 0, 8'hC7);
    finish_frame(1'b1);
    // Valid pulsed during WAIT_DONE and withdrawn: nothing transfers, outputs hold
    grant(4'b0010, 32'h00006600, 1, 8'h66);
    tx_busy = 1'b1;
    @(negedge clk_50m); #1;
    @(negedge clk_50m); #1;
    req_valid = 4'b0100;
    #1;
    chk("ready_wait_done", 32'(req_ready), 32'd0);
    @(negedge clk_50m); #1;
    req_valid = '0;
    tx_busy = 1'b0;
    @(negedge clk_50m); #1;
    chk("pulse_frame_done", 32'(frame_done), 32'd1);
    repeat (4) begin
      @(negedge clk_50m); #1;
      chk("idle_tx_en_n", 32'(tx_en_n), 32'd1);
      chk("idle_grant_id", 32'(grant_id), 32'd1);
      chk("idle_tx_data", 32'(tx_data), 32'h66);
      chk("idle_frame_done", 32'(frame_done), 32'd0);
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
